// File: rtl/burst_window_extractor_pkg.sv
// Shared definitions for the sync-chain burst window extractor: stream widths
// and the window FSM state encoding.
package burst_window_extractor_pkg;

  localparam int SAMPLE_W = 32;
  localparam int PHASE_W  = 16;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    PASS = 2'd2
  } state_t;

endpackage

// File: rtl/burst_window_extractor.sv
// Cuts a fixed-length sample window out of the delayed sample stream each time
// the plateau detector flags a burst, latching the detector phase alongside it.
module burst_window_extractor
  import burst_window_extractor_pkg::*;
#(
  parameter int WINDOW_LEN = 64,
  parameter int SKIP_LEN   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] i_tdata,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  input  logic [PHASE_W-1:0]  d_tdata,
  input  logic                d_tlast,
  input  logic                d_tvalid,
  output logic                d_tready,
  output logic [SAMPLE_W-1:0] o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic [PHASE_W-1:0]  phase_out,
  output logic                phase_valid,
  output logic [CNT_W-1:0]    missed_cnt
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] SKIP_LAST = (SKIP_LEN > 0) ? CNT_W'(SKIP_LEN - 1) : '0;

  state_t             state, state_next;
  logic [CNT_W-1:0]   skip_cnt, skip_next;
  logic [CNT_W-1:0]   win_cnt, win_next;
  logic [PHASE_W-1:0] phase_next;
  logic               phase_valid_next;
  logic [CNT_W-1:0]   missed_next;
  logic               beat;

  // The sample stream's own tlast carries no meaning here; burst framing comes from the detector.
  logic unused_i_tlast;
  assign unused_i_tlast = i_tlast;

  // Both streams move together, and only PASS can be held off by the output side.
  assign beat     = i_tvalid & d_tvalid & ((state != PASS) | o_tready);
  assign i_tready = beat;
  assign d_tready = beat;

  assign o_tdata  = i_tdata;
  assign o_tvalid = i_tvalid & d_tvalid & (state == PASS);
  assign o_tlast  = (state == PASS) & (win_cnt == WIN_LAST);

  always_comb begin
    state_next       = state;
    skip_next        = skip_cnt;
    win_next         = win_cnt;
    phase_next       = phase_out;
    phase_valid_next = phase_valid;
    missed_next      = missed_cnt;

    if (beat) begin
      case (state)
        IDLE: begin
          if (d_tlast) begin
            phase_next       = d_tdata;
            phase_valid_next = 1'b1;
            if (SKIP_LEN > 0) begin
              state_next = SKIP;
              skip_next  = '0;
            end else begin
              state_next = PASS;
              win_next   = '0;
            end
          end
        end
        SKIP: begin
          skip_next = skip_cnt + 1'b1;
          if (skip_cnt == SKIP_LAST) begin
            state_next = PASS;
            win_next   = '0;
          end
        end
        PASS: begin
          win_next = win_cnt + 1'b1;
          if (win_cnt == WIN_LAST) begin
            state_next       = IDLE;
            phase_valid_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase

      // A detection that lands while a window is in flight is only counted, never honoured.
      if ((state != IDLE) && d_tlast && (missed_cnt != '1)) begin
        missed_next = missed_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= IDLE;
      skip_cnt    <= '0;
      win_cnt     <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      missed_cnt  <= '0;
    end else begin
      state       <= state_next;
      skip_cnt    <= skip_next;
      win_cnt     <= win_next;
      phase_out   <= phase_next;
      phase_valid <= phase_valid_next;
      missed_cnt  <= missed_next;
    end
  end

endmodule
